// File: rtl/led_fade_driver_if.sv
// -----------------------------------------------------------------------------
// led_fade_driver_if
// Bundles the PIO-facing target bus and the LED-facing outputs of the
// LED fade driver.
//   pio_in [7:0] : per-LED on/off targets from the PIO out_port
//   led    [7:0] : PWM-modulated LED drive, active-high
//   busy         : high while any LED level differs from its target
// Modports:
//   master : the side that writes targets and watches the LEDs
//   slave  : the fade driver itself
// -----------------------------------------------------------------------------
interface led_fade_driver_if;
    logic [7:0] pio_in;
    logic [7:0] led;
    logic       busy;

    modport master (
        output pio_in,
        input  led,
        input  busy
    );

    modport slave (
        input  pio_in,
        output led,
        output busy
    );
endinterface

// File: rtl/led_fade_driver.sv
// -----------------------------------------------------------------------------
// led_fade_driver
// Sits between the LED PIO out_port and the board LED pins. Each PIO bit is
// the on/off target of one LED; a 4-bit brightness level per LED ramps one
// step toward its target on every prescaler tick, and each level drives a
// 255-cycle PWM so that software writes show up as smooth fades.
//
// Parameters:
//   RAMP_DIV : clock cycles per brightness step (2 .. 2**20)
// Ports:
//   i_clk    : system clock (same clock as the PIO)
//   i_reset  : synchronous, active-high reset
//   io_bus   : led_fade_driver_if.slave (pio_in in, led/busy out)
// Build option:
//   LED_FADE_GAMMA_EN : when defined, level-to-duty uses a gamma table;
//                       otherwise the map is linear (duty = lvl * 17).
// -----------------------------------------------------------------------------
module led_fade_driver #(
    parameter int unsigned RAMP_DIV = 50000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    led_fade_driver_if.slave      io_bus
);

    // 20 bits covers the largest legal divider (2**20 - 1 terminal count).
    localparam int unsigned        PRE_W    = 20;
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(RAMP_DIV - 32'd1);
    localparam logic [PRE_W-1:0]   PRE_ONE  = PRE_W'(32'd1);
    localparam logic [7:0]         PWM_LAST = 8'd254;

    logic [7:0]       r_tgt;
    logic [3:0]       r_lvl [8];
    logic [PRE_W-1:0] r_pre;
    logic [7:0]       r_pwm;
    logic [7:0]       r_led;
    logic             r_busy;

    logic             w_tick;
    logic [3:0]       w_lvl_next [8];
    logic [7:0]       w_led_next;
    logic             w_busy_next;

    // Brightness level to PWM duty; level 0 is dark and level 15 is fully on
    // in both maps.
    function automatic logic [7:0] f_duty(input logic [3:0] lvl);
`ifdef LED_FADE_GAMMA_EN
        case (lvl)
            4'd0:    f_duty = 8'd0;
            4'd1:    f_duty = 8'd1;
            4'd2:    f_duty = 8'd2;
            4'd3:    f_duty = 8'd3;
            4'd4:    f_duty = 8'd5;
            4'd5:    f_duty = 8'd7;
            4'd6:    f_duty = 8'd10;
            4'd7:    f_duty = 8'd14;
            4'd8:    f_duty = 8'd19;
            4'd9:    f_duty = 8'd26;
            4'd10:   f_duty = 8'd35;
            4'd11:   f_duty = 8'd48;
            4'd12:   f_duty = 8'd66;
            4'd13:   f_duty = 8'd91;
            4'd14:   f_duty = 8'd128;
            4'd15:   f_duty = 8'd255;
            default: f_duty = 8'd0;
        endcase
`else
        // lvl * 17 == lvl * 16 + lvl, i.e. the nibble repeated.
        f_duty = {lvl, lvl};
`endif
    endfunction

    // Prescaler terminal count marks a brightness step.
    always_comb begin
        w_tick = (r_pre == PRE_LAST);
    end

    // Next level per LED: step toward the target on a tick, saturating at 0/15.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_lvl_next[i] = r_lvl[i];
            if (w_tick && r_tgt[i] && (r_lvl[i] != 4'd15)) begin
                w_lvl_next[i] = r_lvl[i] + 4'd1;
            end else if (w_tick && !r_tgt[i] && (r_lvl[i] != 4'd0)) begin
                w_lvl_next[i] = r_lvl[i] - 4'd1;
            end else begin
                w_lvl_next[i] = r_lvl[i];
            end
        end
    end

    // PWM compare; duty 255 beats every pwm value since pwm tops out at 254.
    always_comb begin
        w_led_next = 8'd0;
        for (int i = 0; i < 8; i++) begin
            w_led_next[i] = (r_pwm < f_duty(r_lvl[i]));
        end
    end

    // Busy when any level is not yet at 15 * target (0 or 15).
    always_comb begin
        w_busy_next = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (r_lvl[i] != {4{r_tgt[i]}}) begin
                w_busy_next = 1'b1;
            end else begin
                w_busy_next = w_busy_next;
            end
        end
    end

    // State registers; reset clears everything so LEDs go dark immediately.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tgt  <= 8'd0;
            r_pre  <= {PRE_W{1'b0}};
            r_pwm  <= 8'd0;
            r_led  <= 8'd0;
            r_busy <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_lvl[i] <= 4'd0;
            end
        end else begin
            // The tick in this edge still sees the previous target.
            r_tgt  <= io_bus.pio_in;
            r_pre  <= (r_pre == PRE_LAST) ? {PRE_W{1'b0}} : (r_pre + PRE_ONE);
            r_pwm  <= (r_pwm == PWM_LAST) ? 8'd0 : (r_pwm + 8'd1);
            r_led  <= w_led_next;
            r_busy <= w_busy_next;
            for (int i = 0; i < 8; i++) begin
                r_lvl[i] <= w_lvl_next[i];
            end
        end
    end

    assign io_bus.led  = r_led;
    assign io_bus.busy = r_busy;

endmodule

// File: tb/tb_led_fade_driver.sv
// -----------------------------------------------------------------------------
// tb_led_fade_driver
// Bench for led_fade_driver with RAMP_DIV = 4. A behavioural model (integer
// levels, modular counters) predicts led/busy every cycle; a vector table and
// a few hand-written sequences cover reset, fade-in, reversal, reset mid-fade
// and saturation; a randomized phase exercises arbitrary target patterns.
// -----------------------------------------------------------------------------
module tb_led_fade_driver;

    localparam int DIV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    led_fade_driver_if bus();

    led_fade_driver #(.RAMP_DIV(DIV)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int         m_tgt [8];
    int         m_lvl [8];
    int         m_pre;
    int         m_pwm;
    logic [7:0] m_led;
    logic       m_busy;

    function automatic int duty_of(input int l);
`ifdef LED_FADE_GAMMA_EN
        int gam [16] = '{0, 1, 2, 3, 5, 7, 10, 14, 19, 26, 35, 48, 66, 91, 128, 255};
        return gam[l];
`else
        return l * 17;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    endtask

    // One clock edge of the reference: outputs from pre-edge state, then advance.
    task automatic model_step(input logic [7:0] pio, input logic rst);
        bit tick;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_tgt[i] = 0;
                m_lvl[i] = 0;
            end
            m_pre  = 0;
            m_pwm  = 0;
            m_led  = 8'h00;
            m_busy = 1'b0;
        end else begin
            tick   = (m_pre == DIV - 1);
            m_busy = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_led[i] = (m_pwm < duty_of(m_lvl[i]));
                if (m_lvl[i] != 15 * m_tgt[i]) m_busy = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                if (tick) begin
                    if (m_tgt[i] == 1) m_lvl[i] = (m_lvl[i] + 1 > 15) ? 15 : m_lvl[i] + 1;
                    else               m_lvl[i] = (m_lvl[i] - 1 < 0)  ? 0  : m_lvl[i] - 1;
                end
                m_tgt[i] = int'(pio[i]);
            end
            m_pre = (m_pre + 1) % DIV;
            m_pwm = (m_pwm + 1) % 255;
        end
    endtask

    // Drive inputs, take one edge, compare DUT to the model 1 time unit later.
    task automatic cyc(input logic [7:0] pio, input logic rst);
        bus.pio_in = pio;
        reset      = rst;
        @(posedge clk);
        model_step(pio, rst);
        #1;
        chk("led_vs_model",  {24'd0, bus.led},  {24'd0, m_led});
        chk("busy_vs_model", {31'd0, bus.busy}, {31'd0, m_busy});
    endtask

    typedef struct {
        logic [7:0] pio;
        logic       rst;
        int         n;
        logic [7:0] exp_led;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int k;
        int ones;
        int bad;
        bit seen;

        bus.pio_in = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            m_tgt[i] = 0;
            m_lvl[i] = 0;
        end
        m_pre = 0; m_pwm = 0; m_led = 8'h00; m_busy = 1'b0;

        // pio, rst, cycles, led after, busy after
        tbl[0] = '{8'hFF, 1'b1,   3, 8'h00, 1'b0};  // reset held with targets high
        tbl[1] = '{8'hFF, 1'b0,   1, 8'h00, 1'b0};  // first cycle after release
        tbl[2] = '{8'hFF, 1'b0,   1, 8'h00, 1'b1};  // busy two cycles after target
        tbl[3] = '{8'hFF, 1'b0, 100, 8'hFF, 1'b0};  // fully on
        tbl[4] = '{8'h00, 1'b0,   1, 8'hFF, 1'b0};  // target just registered
        tbl[5] = '{8'h00, 1'b0,   1, 8'hFF, 1'b1};  // busy rises, still at 15
        tbl[6] = '{8'h00, 1'b0, 100, 8'h00, 1'b0};  // fully off
        tbl[7] = '{8'h00, 1'b1,   1, 8'h00, 1'b0};  // reset again

        for (int v = 0; v < 8; v++) begin
            for (int c = 0; c < tbl[v].n; c++) cyc(tbl[v].pio, tbl[v].rst);
            chk($sformatf("tbl%0d_led", v),  {24'd0, bus.led},  {24'd0, tbl[v].exp_led});
            chk($sformatf("tbl%0d_busy", v), {31'd0, bus.busy}, {31'd0, tbl[v].exp_busy});
        end

        // Fade in LED0 from reset: busy rises on cycle 2, falls ~15 ticks later.
        cyc(8'h01, 1'b0);
        chk("fadein_busy_c1", {31'd0, bus.busy}, 32'd0);
        cyc(8'h01, 1'b0);
        chk("fadein_busy_c2", {31'd0, bus.busy}, 32'd1);
        k = 2;
        while (bus.busy && k < 200) begin
            cyc(8'h01, 1'b0);
            k++;
        end
        chk("fadein_fall_window", {31'd0, (k >= 57 && k <= 65)}, 32'd1);
        ones = 0; bad = 0;
        for (int c = 0; c < 255; c++) begin
            cyc(8'h01, 1'b0);
            if (bus.led[0]) ones++;
            if (bus.led[7:1] != 7'd0 || bus.busy) bad++;
        end
        chk("fadein_led0_on_cycles", ones, 32'd255);
        chk("fadein_others_dark", bad, 32'd0);

        // Reversal of LED7 at level 6; it must settle back to dark promptly.
        cyc(8'h80, 1'b1);
        k = 0;
        while (m_lvl[7] != 6 && k < 200) begin
            cyc(8'h80, 1'b0);
            k++;
        end
        chk("rev_reach6_timeout", {31'd0, (k < 200)}, 32'd1);
        k = 0;
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b0);
        chk("rev_busy_during", {31'd0, bus.busy}, 32'd1);
        while (bus.busy && k < 200) begin
            cyc(8'h00, 1'b0);
            k++;
        end
        chk("rev_fall_bound", {31'd0, (k <= 40)}, 32'd1);
        chk("rev_led_dark", {24'd0, bus.led}, 32'd0);

        // Reset mid-fade near level 9, then a full re-ramp.
        k = 0;
        while (m_lvl[0] != 9 && k < 200) begin
            cyc(8'hFF, 1'b0);
            k++;
        end
        chk("midreset_reach9_timeout", {31'd0, (k < 200)}, 32'd1);
        cyc(8'hFF, 1'b1);
        chk("midreset_led", {24'd0, bus.led}, 32'd0);
        chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
        cyc(8'hFF, 1'b0);
        k = 1;
        seen = 1'b0;
        while ((bus.busy || !seen) && k < 200) begin
            if (bus.busy) seen = 1'b1;
            cyc(8'hFF, 1'b0);
            k++;
        end
        chk("midreset_reramp_window", {31'd0, (k >= 57 && k <= 65)}, 32'd1);

        // Saturation: 100 ticks at full target.
        bad = 0;
        for (int c = 0; c < 100 * DIV; c++) begin
            cyc(8'hFF, 1'b0);
            if (bus.led != 8'hFF || bus.busy) bad++;
        end
        chk("saturation_steady", bad, 32'd0);

        // Randomized targets with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            logic [7:0] p;
            p = ($urandom_range(0, 7) == 0) ? 8'($urandom) : bus.pio_in;
            cyc(p, ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
